// File: rtl/subservient_dbg_arbiter.sv
// SRAM ownership arbiter between the subservient core and a 32-bit Wishbone debug port.
// Debug accesses are serialised into four byte-wide SRAM cycles while the core is held in reset.
module subservient_dbg_arbiter #(
    parameter int sram_aw = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_debug_mode,
    output logic               o_cpu_rst,
    output logic               o_dbg_active,
    input  logic [sram_aw-1:0] i_core_sram_waddr,
    input  logic [7:0]         i_core_sram_wdata,
    input  logic               i_core_sram_wen,
    input  logic [sram_aw-1:0] i_core_sram_raddr,
    output logic [7:0]         o_core_sram_rdata,
    input  logic [31:0]        i_wb_dbg_adr,
    input  logic [31:0]        i_wb_dbg_dat,
    input  logic [3:0]         i_wb_dbg_sel,
    input  logic               i_wb_dbg_we,
    input  logic               i_wb_dbg_stb,
    output logic [31:0]        o_wb_dbg_rdt,
    output logic               o_wb_dbg_ack,
    output logic [sram_aw-1:0] o_sram_waddr,
    output logic [7:0]         o_sram_wdata,
    output logic               o_sram_wen,
    output logic [sram_aw-1:0] o_sram_raddr,
    input  logic [7:0]         i_sram_rdata
);

    typedef enum logic [2:0] {
        CORE    = 3'd0,
        HALT    = 3'd1,
        DEBUG   = 3'd2,
        XFER    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t             state_r;
    logic               halt_cnt_r;
    logic [1:0]         lane_r;
    logic [sram_aw-3:0] adr_r;
    logic [31:0]        dat_r;
    logic [3:0]         sel_r;
    logic               we_r;
    logic               ack_r;
    logic               ack_rd_r;
    logic               dbg_active_r;
    logic [23:0]        rd_r;

    logic [sram_aw-1:0] xfer_addr_s;
    logic               stb_take_s;
    logic               adr_unused_s;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        case (lane)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase
    endfunction

    assign xfer_addr_s  = {adr_r, lane_r};
    // A request still high during its own ack cycle must not be taken twice.
    assign stb_take_s   = i_wb_dbg_stb & ~ack_r;
    assign adr_unused_s = ^{i_wb_dbg_adr[31:sram_aw], i_wb_dbg_adr[1:0]};

    assign o_cpu_rst         = i_rst | (state_r != CORE);
    assign o_dbg_active      = dbg_active_r;
    assign o_wb_dbg_ack      = ack_r;
    assign o_core_sram_rdata = i_sram_rdata;
    // Lane 3 arrives from the SRAM in the ack cycle itself, so it is forwarded live.
    assign o_wb_dbg_rdt      = (ack_r & ack_rd_r) ? {i_sram_rdata, rd_r} : 32'h0000_0000;

    // Ownership FSM, debug transaction sequencing and registered ack/status.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= CORE;
            halt_cnt_r   <= 1'b0;
            lane_r       <= 2'd0;
            adr_r        <= {(sram_aw-2){1'b0}};
            dat_r        <= 32'h0000_0000;
            sel_r        <= 4'h0;
            we_r         <= 1'b0;
            ack_r        <= 1'b0;
            ack_rd_r     <= 1'b0;
            dbg_active_r <= 1'b0;
            rd_r         <= 24'h00_0000;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                CORE: begin
                    if (stb_take_s) begin
                        ack_r    <= 1'b1;
                        ack_rd_r <= 1'b0;
                    end
                    if (i_debug_mode) begin
                        state_r    <= HALT;
                        halt_cnt_r <= 1'b0;
                    end
                end
                HALT: begin
                    if (stb_take_s) begin
                        ack_r    <= 1'b1;
                        ack_rd_r <= 1'b0;
                    end
                    halt_cnt_r <= 1'b1;
                    if (halt_cnt_r) begin
                        state_r      <= DEBUG;
                        dbg_active_r <= 1'b1;
                    end
                end
                DEBUG: begin
                    if (stb_take_s) begin
                        adr_r   <= i_wb_dbg_adr[sram_aw-1:2];
                        dat_r   <= i_wb_dbg_dat;
                        sel_r   <= i_wb_dbg_sel;
                        we_r    <= i_wb_dbg_we;
                        lane_r  <= 2'd0;
                        state_r <= XFER;
                    end else if (!i_debug_mode) begin
                        state_r      <= RELEASE;
                        dbg_active_r <= 1'b0;
                    end
                end
                XFER: begin
                    if (ack_r) begin
                        // A release requested mid-transaction takes effect right after the ack.
                        if (i_debug_mode) begin
                            state_r <= DEBUG;
                        end else begin
                            state_r      <= RELEASE;
                            dbg_active_r <= 1'b0;
                        end
                    end else begin
                        lane_r <= lane_r + 2'd1;
                        if (!we_r) begin
                            case (lane_r)
                                2'd1:    rd_r[7:0]   <= i_sram_rdata;
                                2'd2:    rd_r[15:8]  <= i_sram_rdata;
                                2'd3:    rd_r[23:16] <= i_sram_rdata;
                                default: rd_r        <= rd_r;
                            endcase
                        end
                        if (lane_r == 2'd3) begin
                            ack_r    <= 1'b1;
                            ack_rd_r <= ~we_r;
                        end
                    end
                end
                RELEASE: begin
                    if (stb_take_s) begin
                        ack_r    <= 1'b1;
                        ack_rd_r <= 1'b0;
                    end
                    state_r <= CORE;
                end
                default: begin
                    state_r      <= CORE;
                    dbg_active_r <= 1'b0;
                end
            endcase
        end
    end

    // SRAM port steering: core pass-through, gated write, or debug lane access.
    always_comb begin
        o_sram_waddr = i_core_sram_waddr;
        o_sram_wdata = i_core_sram_wdata;
        o_sram_raddr = i_core_sram_raddr;
        o_sram_wen   = 1'b0;
        case (state_r)
            CORE: begin
                o_sram_wen = i_core_sram_wen;
            end
            XFER: begin
                o_sram_waddr = xfer_addr_s;
                o_sram_raddr = xfer_addr_s;
                o_sram_wdata = lane_byte(dat_r, lane_r);
                o_sram_wen   = we_r & sel_r[lane_r] & ~ack_r;
            end
            default: begin
                o_sram_wen = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_subservient_dbg_arbiter.sv
// Directed bench for subservient_dbg_arbiter with a transaction-level reference model
// and a byte-wide SRAM with one-cycle read latency.
module tb_subservient_dbg_arbiter;

    logic        clk = 1'b0;
    logic        rst, dbg;
    logic [9:0]  core_waddr, core_raddr;
    logic [7:0]  core_wdata, core_rdata;
    logic        core_wen;
    logic [31:0] wb_adr, wb_dat, wb_rdt;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_ack;
    logic        cpu_rst, dbg_active;
    logic [9:0]  s_waddr, s_raddr;
    logic [7:0]  s_wdata, sram_rdata;
    logic        s_wen;
    logic [7:0]  sram [0:1023];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (s_wen) sram[s_waddr] <= s_wdata;
        sram_rdata <= sram[s_raddr];
    end

    subservient_dbg_arbiter #(.sram_aw(10)) dut (
        .i_clk(clk), .i_rst(rst), .i_debug_mode(dbg),
        .o_cpu_rst(cpu_rst), .o_dbg_active(dbg_active),
        .i_core_sram_waddr(core_waddr), .i_core_sram_wdata(core_wdata),
        .i_core_sram_wen(core_wen), .i_core_sram_raddr(core_raddr),
        .o_core_sram_rdata(core_rdata),
        .i_wb_dbg_adr(wb_adr), .i_wb_dbg_dat(wb_dat), .i_wb_dbg_sel(wb_sel),
        .i_wb_dbg_we(wb_we), .i_wb_dbg_stb(wb_stb),
        .o_wb_dbg_rdt(wb_rdt), .o_wb_dbg_ack(wb_ack),
        .o_sram_waddr(s_waddr), .o_sram_wdata(s_wdata), .o_sram_wen(s_wen),
        .o_sram_raddr(s_raddr), .i_sram_rdata(sram_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ownership phase, cycle index within a transaction, expected SRAM contents read.
    initial begin : model
        int mode;      // 0 core, 1 halt, 2 debug idle, 3 transfer, 4 release
        int halt_n, k, base, a;
        logic valid, ack, ackrd, nack, mwe, ewen;
        logic [31:0] rdv, mdat;
        logic [3:0]  msel;
        valid = 1'b0; mode = 0; halt_n = 0; k = 0; base = 0; a = 0;
        ack = 1'b0; ackrd = 1'b0; mwe = 1'b0; rdv = 32'h0; mdat = 32'h0; msel = 4'h0;
        forever begin
            @(negedge clk);
            if (!valid) begin
                if (rst === 1'b1) begin
                    valid = 1'b1; mode = 0; k = 0; ack = 1'b0; ackrd = 1'b0;
                end
            end else begin
                check("m_cpu_rst", cpu_rst, (rst || mode != 0));
                check("m_dbg_active", dbg_active, (mode == 2 || mode == 3));
                check("m_ack", wb_ack, ack);
                check("m_rdt", wb_rdt, (ack && ackrd) ? rdv : 32'h0);
                check("m_core_rdata", core_rdata, sram_rdata);
                if (mode == 0) begin
                    check("m_core_wen", s_wen, core_wen);
                    check("m_core_waddr", s_waddr, core_waddr);
                    check("m_core_wdata", s_wdata, core_wdata);
                    check("m_core_raddr", s_raddr, core_raddr);
                end else if (mode == 3 && k < 4) begin
                    a = (base * 4 + k) % 1024;
                    ewen = mwe && msel[k];
                    check("m_lane_raddr", s_raddr, a);
                    check("m_lane_wen", s_wen, ewen);
                    if (ewen) begin
                        check("m_lane_waddr", s_waddr, a);
                        check("m_lane_wdata", s_wdata, mdat[8*k +: 8]);
                    end
                end else begin
                    check("m_wen_gated", s_wen, 1'b0);
                end

                nack = 1'b0;
                if (rst) begin
                    mode = 0; k = 0; ackrd = 1'b0;
                end else begin
                    case (mode)
                        0: begin
                            if (wb_stb && !ack) begin nack = 1'b1; ackrd = 1'b0; end
                            if (dbg) begin mode = 1; halt_n = 0; end
                        end
                        1: begin
                            if (wb_stb && !ack) begin nack = 1'b1; ackrd = 1'b0; end
                            halt_n++;
                            if (halt_n == 2) mode = 2;
                        end
                        2: begin
                            if (wb_stb && !ack) begin
                                base = int'(wb_adr % 32'd1024) / 4;
                                mdat = wb_dat; msel = wb_sel; mwe = wb_we;
                                for (int j = 0; j < 4; j++) rdv[8*j +: 8] = sram[(base * 4 + j) % 1024];
                                mode = 3; k = 0;
                            end else if (!dbg) begin
                                mode = 4;
                            end
                        end
                        3: begin
                            if (k < 3) k++;
                            else if (k == 3) begin k = 4; nack = 1'b1; ackrd = !mwe; end
                            else mode = dbg ? 2 : 4;
                        end
                        4: begin
                            if (wb_stb && !ack) begin nack = 1'b1; ackrd = 1'b0; end
                            mode = 0;
                        end
                        default: mode = 0;
                    endcase
                end
                ack = nack;
            end
        end
    end

    // Issue one debug-port request; returns cycles from stb sample to ack (-1 if none within 8).
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, input int drop_dbg_at, input int rst_at,
                       output int lat, output logic [31:0] rdt);
        tick();
        wb_stb = 1'b1; wb_adr = a; wb_dat = d; wb_sel = s; wb_we = w;
        lat = -1; rdt = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == drop_dbg_at) dbg = 1'b0;
            if (i == rst_at) begin rst = 1'b1; dbg = 1'b0; wb_stb = 1'b0; end
            if (i == rst_at + 1) rst = 1'b0;
            #3;
            if (wb_ack) begin lat = i; rdt = wb_rdt; break; end
        end
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] rdt;
        logic [9:0]  pre_a [0:9];
        logic [7:0]  pre_d [0:9];
        logic        seen;
        pre_a = '{10'h200, 10'h201, 10'h202, 10'h203, 10'h3FF, 10'h300, 10'h108, 10'h109, 10'h10A, 10'h10B};
        pre_d = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        rst = 1'b1; dbg = 1'b0;
        core_waddr = 10'h0; core_raddr = 10'h0; core_wdata = 8'h0; core_wen = 1'b0;
        wb_adr = 32'h0; wb_dat = 32'h0; wb_sel = 4'h0; wb_we = 1'b0; wb_stb = 1'b0;
        repeat (3) tick();
        #3;
        check("reset_cpu_rst", cpu_rst, 1'b1);
        check("reset_ack", wb_ack, 1'b0);
        check("reset_rdt", wb_rdt, 32'h0);
        check("reset_dbg_active", dbg_active, 1'b0);
        tick();
        rst = 1'b0;
        #3;
        check("core_cpu_rst_low", cpu_rst, 1'b0);

        // Preload through the core pass-through path.
        for (int i = 0; i < 10; i++) begin
            tick();
            core_wen = 1'b1; core_waddr = pre_a[i]; core_wdata = pre_d[i];
        end
        tick();
        core_wen = 1'b0;
        tick();
        check("preload_200", sram[10'h200], 8'hAA);

        // Handover: debug requested in cycle c.
        tick();
        dbg = 1'b1;
        #3;
        check("handover_c_cpu_rst", cpu_rst, 1'b0);
        tick();
        core_wen = 1'b1; core_waddr = 10'h3FF; core_wdata = 8'h55;
        #3;
        check("handover_c1_cpu_rst", cpu_rst, 1'b1);
        check("handover_c1_active", dbg_active, 1'b0);
        check("handover_c1_wen", s_wen, 1'b0);
        tick();
        #3;
        check("handover_c2_wen", s_wen, 1'b0);
        tick();
        #3;
        check("handover_c3_active", dbg_active, 1'b1);
        check("handover_c3_wen", s_wen, 1'b0);
        tick();
        core_wen = 1'b0;
        #3;
        check("handover_3ff_untouched", sram[10'h3FF], 8'h00);

        // Full write.
        txn(32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 1'b1, -1, -1, lat, rdt);
        check("full_write_latency", lat, 5);
        check("full_write_rdt", rdt, 32'h0);
        check("full_write_mem", {sram[10'h107], sram[10'h106], sram[10'h105], sram[10'h104]}, 32'hDEAD_BEEF);

        // Address wrap, upper and low address bits ignored.
        txn(32'hFFFF_FFFD, 32'h0A0B_0C0D, 4'h8, 1'b1, -1, -1, lat, rdt);
        check("wrap_latency", lat, 5);
        check("wrap_mem_3ff", sram[10'h3FF], 8'h0A);

        // Partial write over preset bytes, then read back.
        txn(32'h0000_0200, 32'h1122_3344, 4'h5, 1'b1, -1, -1, lat, rdt);
        check("partial_write_latency", lat, 5);
        txn(32'h0000_0200, 32'h0, 4'h0, 1'b0, -1, -1, lat, rdt);
        check("partial_read_latency", lat, 5);
        check("partial_read_rdt", rdt, 32'hAA22_AA44);

        // Release requested mid-read.
        txn(32'h0000_0104, 32'h0, 4'h0, 1'b0, 2, -1, lat, rdt);
        check("release_read_latency", lat, 5);
        check("release_read_rdt", rdt, 32'hDEAD_BEEF);
        tick();
        #3;
        check("release_cpu_rst_held", cpu_rst, 1'b1);
        check("release_active_low", dbg_active, 1'b0);
        tick();
        core_wen = 1'b1; core_waddr = 10'h010; core_wdata = 8'h77;
        #3;
        check("release_cpu_rst_low", cpu_rst, 1'b0);
        check("release_passthru_wen", s_wen, 1'b1);
        check("release_passthru_waddr", s_waddr, 10'h010);
        tick();
        core_wen = 1'b0;

        // Stray access while the core owns the SRAM.
        txn(32'h0000_0300, 32'hFFFF_FFFF, 4'hF, 1'b1, -1, -1, lat, rdt);
        check("stray_latency", lat, 1);
        check("stray_rdt", rdt, 32'h0);
        tick();
        check("stray_mem_300", sram[10'h300], 8'h00);

        // Reset in the middle of a write.
        dbg = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #3;
            if (dbg_active) begin seen = 1'b1; break; end
        end
        check("rst_test_debug_entered", seen, 1'b1);
        txn(32'h0000_0108, 32'h4433_2211, 4'hF, 1'b1, -1, 2, lat, rdt);
        check("rst_no_ack", lat, -1);
        check("rst_lanes_01", {sram[10'h109], sram[10'h108]}, 16'h2211);
        check("rst_lanes_23", {sram[10'h10B], sram[10'h10A]}, 16'h0000);
        check("rst_cpu_rst", cpu_rst, 1'b0);
        check("rst_active", dbg_active, 1'b0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
